mux_rr_arbiter: RTL and testbench

//  Shares one N-input data mux between N_REQ requesters. Each requester presents a

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_sel.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: default sizing,
// select-width helper and the output-register state encoding.
package mux_arb_pkg;

    localparam int N_REQ_DEF  = 5;
    localparam int DATA_W_DEF = 4;

    // Select width for an n-way mux; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_sel.sv
// Purely combinational N-way word select. Selects outside 0..N_REQ-1
// return zero so unreachable encodings never leak a stale word.
module mux_sel
    import mux_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int SEL_W = sel_w(N_REQ)
) (
    input  logic [N_REQ*DATA_W-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       y
);

    // Pick the word owned by requester 'sel', zero when out of range.
    always_comb begin
        y = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == SEL_W'(k)) begin
                y = data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one data mux between N_REQ requesters.
// The winning word lands in a one-entry output register drained by a
// valid/ready handshake.
//
//  state    | meaning
//  ---------+--------------------------------------------
//  ST_EMPTY | output register holds no untaken word
//  ST_FULL  | o_data holds a word waiting for i_ready
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int SEL_W = sel_w(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [SEL_W-1:0]        o_ctrl,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_busy
);

    state_t            state_q;
    state_t            state_d;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  cand;
    logic              found;
    logic              load;
    logic [DATA_W-1:0] mux_y;

    // Search for the first requester after the last winner, wrapping at N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = SEL_W'((int'(ptr) + i) % N_REQ);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A load fills the register when it is empty or being drained this cycle.
    assign load = found && ((state_q == ST_EMPTY) || i_ready);

    // One-hot grant for the loading requester; suppressed during reset.
    always_comb begin
        o_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_gnt[k] = i_rst_n && load && (winner == SEL_W'(k));
        end
    end

    mux_sel #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W)
    ) u_mux_sel (
        .data (i_data),
        .sel  (winner),
        .y    (mux_y)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on load, drain when the consumer takes the last word.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && i_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Capture the selected word and advance the priority pointer on load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_ctrl <= '0;
            ptr    <= SEL_W'(N_REQ - 1);
        end else if (load) begin
            o_data <= mux_y;
            o_ctrl <= winner;
            ptr    <= winner;
        end
    end

    assign o_valid = (state_q == ST_FULL);
    assign o_busy  = o_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and random checks for the round-robin mux arbiter.
module tb_mux_rr_arbiter;

    localparam int N      = 5;
    localparam int DW     = 4;
    localparam int SW     = 3;

    logic          i_clk;
    logic          i_rst_n;
    logic [N-1:0]  i_req;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]  o_gnt;
    logic [SW-1:0] o_ctrl;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] words [N];

    mux_rr_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_gnt   (o_gnt),
        .o_ctrl  (o_ctrl),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_words();
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = words[k];
    endtask

    // Clock edge, then settle at the following falling edge.
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_req   = '0;
        #2;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Reference model for the random run.
    logic [SW-1:0] m_ptr;
    logic [SW-1:0] m_ctrl;
    logic [DW-1:0] m_data;
    logic          m_full;
    logic          m_load;
    logic [SW-1:0] m_win;
    logic [N-1:0]  m_gnt;

    initial begin
        i_rst_n = 1'b0;
        i_req   = '0;
        i_ready = 1'b1;
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'hA;
        words[3] = 4'hC; words[4] = 4'hE;
        drive_words();

        // T1: reset held with every requester active
        i_req = 5'b11111;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("t1_valid", 32'(o_valid), 32'h0);
        chk("t1_data",  32'(o_data),  32'h0);
        chk("t1_ctrl",  32'(o_ctrl),  32'h0);
        chk("t1_gnt",   32'(o_gnt),   32'h0);
        chk("t1_busy",  32'(o_busy),  32'h0);
        i_req = '0;
        i_rst_n = 1'b1;

        // T2: single requester 2
        @(negedge i_clk);
        i_req = 5'b00100;
        #1;
        chk("t2_gnt", 32'(o_gnt), 32'h04);
        step();
        chk("t2_valid", 32'(o_valid), 32'h1);
        chk("t2_data",  32'(o_data),  32'hA);
        chk("t2_ctrl",  32'(o_ctrl),  32'h2);
        i_req = '0;

        // T3: all requesting from reset priority, 6 loads
        do_reset();
        i_req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t3_gnt", 32'(o_gnt), 32'(5'b00001 << (i % N)));
            step();
            chk("t3_ctrl", 32'(o_ctrl), 32'(i % N));
            chk("t3_data", 32'(o_data), 32'(words[i % N]));
        end
        // one more load so requester 1 holds the register
        step();
        chk("t4_pre_ctrl", 32'(o_ctrl), 32'h1);
        chk("t4_pre_data", 32'(o_data), 32'h5);

        // T4: backpressure
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_gnt0", 32'(o_gnt), 32'h0);
            step();
            chk("t4_valid", 32'(o_valid), 32'h1);
            chk("t4_ctrl",  32'(o_ctrl),  32'h1);
            chk("t4_data",  32'(o_data),  32'h5);
        end
        i_ready = 1'b1;
        #1;
        chk("t4_gnt_release", 32'(o_gnt), 32'h04);
        step();
        chk("t4_ctrl_after", 32'(o_ctrl), 32'h2);

        // T5: wrap between requesters 3 and 0
        i_req = 5'b01000;
        step();
        chk("t5_ctrl3", 32'(o_ctrl), 32'h3);
        i_req = 5'b01001;
        #1; chk("t5_gnt_a", 32'(o_gnt), 32'h01); step();
        chk("t5_ctrl_a", 32'(o_ctrl), 32'h0);
        #1; chk("t5_gnt_b", 32'(o_gnt), 32'h08); step();
        chk("t5_ctrl_b", 32'(o_ctrl), 32'h3);
        #1; chk("t5_gnt_c", 32'(o_gnt), 32'h01); step();
        chk("t5_ctrl_c", 32'(o_ctrl), 32'h0);

        // T6: reset pulse while full
        chk("t6_valid_before", 32'(o_valid), 32'h1);
        i_req = 5'b11111;
        i_rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(o_valid), 32'h0);
        chk("t6_gnt_rst",   32'(o_gnt),   32'h0);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("t6_gnt_first", 32'(o_gnt), 32'h01);
        step();
        chk("t6_ctrl", 32'(o_ctrl), 32'h0);
        chk("t6_valid", 32'(o_valid), 32'h1);

        // Random regression against a behavioural model
        do_reset();
        m_ptr  = SW'(N - 1);
        m_ctrl = '0;
        m_data = '0;
        m_full = 1'b0;
        for (int c = 0; c < 256; c++) begin
            i_req   = N'($urandom_range(0, 31));
            i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) words[k] = DW'($urandom_range(0, 15));
            drive_words();
            m_win = '0;
            m_load = 1'b0;
            for (int j = 1; j <= N; j++) begin
                if (!m_load && i_req[(int'(m_ptr) + j) % N]) begin
                    m_load = 1'b1;
                    m_win  = SW'((int'(m_ptr) + j) % N);
                end
            end
            m_load = m_load && (!m_full || i_ready);
            m_gnt = m_load ? N'(1 << m_win) : '0;
            #1;
            chk("rnd_valid", 32'(o_valid), 32'(m_full));
            chk("rnd_gnt",   32'(o_gnt),   32'(m_gnt));
            if (m_full && i_ready) begin
                chk("rnd_ctrl", 32'(o_ctrl), 32'(m_ctrl));
                chk("rnd_data", 32'(o_data), 32'(m_data));
            end
            if (m_load) begin
                m_data = words[m_win];
                m_ctrl = m_win;
                m_ptr  = m_win;
                m_full = 1'b1;
            end else if (m_full && i_ready) begin
                m_full = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
